// File: rtl/rf_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: data width
// default, RF address width, arbiter state encodings and a one-hot helper.
`ifndef N
`define N 32
`endif

package rf_wr_arbiter_pkg;

    localparam int RF_ADDR_W = 5;

    // Arbiter state encodings
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_PEND  = 2'd1;
    localparam logic [1:0] ARB_FORCE = 2'd2;

    // One-hot register mask for a destination register index
    function automatic logic [31:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding {rd, data} for LLU results that lost
// arbitration. The head entry is read combinationally so the arbiter can
// grant it in the same cycle. The caller never pushes into a full FIFO
// unless it also pops.
module rf_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Storage write; contents need no reset because r_count gates validity
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback always wins;
// LLU results bypass straight to the port when it is free and nothing is
// queued, otherwise they wait in rf_wr_fifo. A starvation guard raises
// o_stall_req once the queued head has lost MAX_WAIT times.
// Optional feature macro: RF_ARB_PERF_EN (conflict performance counter).
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int N         = `N,
    parameter int BUF_DEPTH = 2,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wb_wr,
    input  logic [RF_ADDR_W-1:0] i_wb_rd,
    input  logic [N-1:0]         i_wb_data,
    input  logic                 i_llu_vld,
    input  logic [RF_ADDR_W-1:0] i_llu_rd,
    input  logic [N-1:0]         i_llu_data,
    output logic                 o_llu_rdy,
    output logic                 o_rf_wr,
    output logic [RF_ADDR_W-1:0] o_rf_rd,
    output logic [N-1:0]         o_rf_data,
    output logic                 o_stall_req,
    output logic [31:0]          o_pend_mask,
    output logic [31:0]          o_conflict_cnt
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic                 r_rf_wr;
    logic [RF_ADDR_W-1:0] r_rf_rd;
    logic [N-1:0]         r_rf_data;
    logic                 r_stall_req;
    logic [31:0]          r_pend_mask;
    logic [1:0]           r_state;
    logic [WW-1:0]        r_wait;

    logic [RF_ADDR_W+N-1:0] w_head;
    logic [RF_ADDR_W-1:0]   w_head_rd;
    logic [N-1:0]           w_head_data;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic [CW-1:0]          w_count_next;
    logic                   w_wb_wen;
    logic                   w_llu_nz;
    logic                   w_head_grant;
    logic                   w_head_lost;
    logic                   w_bypass;
    logic                   w_push;
    logic [31:0]            w_pend_next;
    logic [WW-1:0]          w_wait_next;
    logic [1:0]             w_state_next;

    rf_wr_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (RF_ADDR_W + N)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_head_grant),
        .i_data  ({i_llu_rd, i_llu_data}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_rd   = w_head[N +: RF_ADDR_W];
    assign w_head_data = w_head[N-1:0];

    // x0 writes are dropped at the port and never enter the queue
    assign w_wb_wen     = i_wb_wr && (i_wb_rd != '0);
    assign w_llu_nz     = (i_llu_rd != '0);
    assign w_head_grant = !i_wb_wr && !w_empty;
    assign w_head_lost  = i_wb_wr && !w_empty;
    assign w_bypass     = !i_wb_wr && w_empty && i_llu_vld;
    assign o_llu_rdy    = !w_full || w_head_grant;
    assign w_push       = i_llu_vld && o_llu_rdy && !w_bypass && w_llu_nz;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_head_grant);

    // Pending-result mask: clear the granted head, then mark the new enqueue
    always_comb begin
        w_pend_next = r_pend_mask;
        if (w_head_grant) begin
            w_pend_next = w_pend_next & ~rd_onehot(w_head_rd);
        end
        if (w_push) begin
            w_pend_next = w_pend_next | rd_onehot(i_llu_rd);
        end
    end

    // Head wait counter: counts losses to the pipeline, saturating at MAX_WAIT
    always_comb begin
        w_wait_next = r_wait;
        if (w_head_grant || w_empty) begin
            w_wait_next = '0;
        end else if (w_head_lost && (r_wait != WAIT_MAX)) begin
            w_wait_next = r_wait + WW'(1);
        end
    end

    // Starvation FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_push) begin
                    w_state_next = ARB_PEND;
                end
            end
            ARB_PEND: begin
                if (w_head_grant) begin
                    w_state_next = (w_count_next == '0) ? ARB_IDLE : ARB_PEND;
                end else if (w_wait_next == WAIT_MAX) begin
                    w_state_next = ARB_FORCE;
                end
            end
            ARB_FORCE: begin
                if (w_head_grant) begin
                    w_state_next = (w_count_next == '0) ? ARB_IDLE : ARB_PEND;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_wait      <= '0;
            r_stall_req <= 1'b0;
            r_pend_mask <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait      <= w_wait_next;
            r_stall_req <= (w_state_next == ARB_FORCE);
            r_pend_mask <= w_pend_next;
        end
    end

    // RF write port: register the winner; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_wr   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_wr <= 1'b0;
            if (i_wb_wr) begin
                if (w_wb_wen) begin
                    r_rf_wr   <= 1'b1;
                    r_rf_rd   <= i_wb_rd;
                    r_rf_data <= i_wb_data;
                end
            end else if (!w_empty) begin
                r_rf_wr   <= 1'b1;
                r_rf_rd   <= w_head_rd;
                r_rf_data <= w_head_data;
            end else if (i_llu_vld && w_llu_nz) begin
                r_rf_wr   <= 1'b1;
                r_rf_rd   <= i_llu_rd;
                r_rf_data <= i_llu_data;
            end
        end
    end

`ifdef RF_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;

    // Count cycles where a real pipeline write collides with a real LLU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_wb_wen && (!w_empty || (i_llu_vld && w_llu_nz))) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`else
    assign o_conflict_cnt = '0;
`endif

    assign o_rf_wr     = r_rf_wr;
    assign o_rf_rd     = r_rf_rd;
    assign o_rf_data   = r_rf_data;
    assign o_stall_req = r_stall_req;
    assign o_pend_mask = r_pend_mask;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: stimulus pushes expected RF writes,
// a monitor pops and compares every observed write. Status outputs are
// checked directly against hand-computed constants.
`timescale 1ns/1ps
module tb_rf_wr_arbiter;

`ifdef RF_ARB_PERF_EN
    localparam int EXP_CONF = 3;
`else
    localparam int EXP_CONF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_wb_wr = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic [31:0] i_wb_data = '0;
    logic        i_llu_vld = 1'b0;
    logic [4:0]  i_llu_rd = '0;
    logic [31:0] i_llu_data = '0;
    logic        o_llu_rdy;
    logic        o_rf_wr;
    logic [4:0]  o_rf_rd;
    logic [31:0] o_rf_data;
    logic        o_stall_req;
    logic [31:0] o_pend_mask;
    logic [31:0] o_conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    rf_wr_arbiter #(.N(32), .BUF_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wb_wr        (i_wb_wr),
        .i_wb_rd        (i_wb_rd),
        .i_wb_data      (i_wb_data),
        .i_llu_vld      (i_llu_vld),
        .i_llu_rd       (i_llu_rd),
        .i_llu_data     (i_llu_data),
        .o_llu_rdy      (o_llu_rdy),
        .o_rf_wr        (o_rf_wr),
        .o_rf_rd        (o_rf_rd),
        .o_rf_data      (o_rf_data),
        .o_stall_req    (o_stall_req),
        .o_pend_mask    (o_pend_mask),
        .o_conflict_cnt (o_conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Advance one clock; returns after the monitor has sampled this edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wb(input logic wr, input logic [4:0] rd, input logic [31:0] d);
        i_wb_wr = wr; i_wb_rd = rd; i_wb_data = d;
    endtask

    task automatic set_llu(input logic vld, input logic [4:0] rd, input logic [31:0] d);
        i_llu_vld = vld; i_llu_rd = rd; i_llu_data = d;
    endtask

    task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    // Monitor: every observed RF write must match the oldest expectation
    always begin
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (rst_n && o_rf_wr) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rf_write_unexpected: got x%0d=0x%08h, required no write", o_rf_rd, o_rf_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_rf_rd, o_rf_data} !== e) begin
                    n_bad++;
                    $display("FAIL rf_write: got x%0d=0x%08h, required x%0d=0x%08h",
                             o_rf_rd, o_rf_data, e[36:32], e[31:0]);
                end else begin
                    $display("ok   rf_write x%0d=0x%08h", o_rf_rd, o_rf_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rf_wr", 32'(o_rf_wr), 32'd0);
        chk("reset_stall", 32'(o_stall_req), 32'd0);
        chk("reset_llu_rdy", 32'(o_llu_rdy), 32'd1);
        rst_n = 1'b1;
        cyc();

        // 1. Two entries buffered, then reset mid-stream
        set_wb(1'b1, 5'd1, 32'hA1A1_0001); set_llu(1'b1, 5'd3, 32'h0000_0333); exp_wr(5'd1, 32'hA1A1_0001);
        cyc();
        set_wb(1'b1, 5'd2, 32'hA2A2_0002); set_llu(1'b1, 5'd4, 32'h0000_0444); exp_wr(5'd2, 32'hA2A2_0002);
        cyc();
        set_wb(1'b1, 5'd0, 32'h0); set_llu(1'b0, 5'd0, 32'h0);
        #1;
        chk("full_llu_rdy", 32'(o_llu_rdy), 32'd0);
        chk("full_pend_mask", o_pend_mask, 32'h0000_0018);
        rst_n = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("midrst_rf_wr", 32'(o_rf_wr), 32'd0);
        chk("midrst_rf_rd", 32'(o_rf_rd), 32'd0);
        chk("midrst_rf_data", o_rf_data, 32'd0);
        chk("midrst_stall", 32'(o_stall_req), 32'd0);
        chk("midrst_pend", o_pend_mask, 32'd0);
        chk("midrst_conflict", o_conflict_cnt, 32'd0);
        chk("midrst_llu_rdy", 32'(o_llu_rdy), 32'd1);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("postrst_no_write", 32'(o_rf_wr), 32'd0);
        end

        // 2. Pipeline-only writes, then an x0 write that must be dropped
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF); exp_wr(5'd5, 32'hDEAD_BEEF);
        cyc();
        set_wb(1'b1, 5'd0, 32'h1234_5678);
        cyc();
        chk("wb_x0_rf_wr", 32'(o_rf_wr), 32'd0);
        chk("wb_x0_hold_rd", 32'(o_rf_rd), 32'd5);
        chk("wb_x0_hold_data", o_rf_data, 32'hDEAD_BEEF);
        set_wb(1'b0, 5'd0, 32'h0);

        // 3. Bypass with empty FIFO, then an LLU x0 result
        set_llu(1'b1, 5'd7, 32'h0000_0012); exp_wr(5'd7, 32'h0000_0012);
        #1;
        chk("bypass_llu_rdy", 32'(o_llu_rdy), 32'd1);
        cyc();
        chk("bypass_pend", o_pend_mask, 32'd0);
        set_llu(1'b1, 5'd0, 32'h0000_0055);
        cyc();
        chk("llu_x0_rf_wr", 32'(o_rf_wr), 32'd0);
        chk("llu_x0_pend", o_pend_mask, 32'd0);
        set_llu(1'b0, 5'd0, 32'h0);

        // 4. Contention and starvation guard
        set_wb(1'b1, 5'd11, 32'hB000_0000); exp_wr(5'd11, 32'hB000_0000);
        set_llu(1'b1, 5'd9, 32'h0000_0099);
        cyc();
        set_llu(1'b0, 5'd0, 32'h0);
        chk("contend_pend9", o_pend_mask, 32'h0000_0200);
        for (int k = 0; k < 5; k++) begin
            set_wb(1'b1, 5'(12 + k), 32'hB000_0010 + 32'(k)); exp_wr(5'(12 + k), 32'hB000_0010 + 32'(k));
            cyc();
            chk($sformatf("starve_stall_%0d", k), 32'(o_stall_req), (k >= 3) ? 32'd1 : 32'd0);
        end
        set_wb(1'b0, 5'd0, 32'h0); exp_wr(5'd9, 32'h0000_0099);
        cyc();
        chk("drain9_stall", 32'(o_stall_req), 32'd0);
        chk("drain9_pend", o_pend_mask, 32'd0);

        // 5. Full FIFO with the pipeline busy, third result held
        set_wb(1'b1, 5'd20, 32'hC000_0020); exp_wr(5'd20, 32'hC000_0020);
        set_llu(1'b1, 5'd3, 32'h0000_0033);
        cyc();
        set_wb(1'b1, 5'd21, 32'hC000_0021); exp_wr(5'd21, 32'hC000_0021);
        set_llu(1'b1, 5'd4, 32'h0000_0044);
        #1;
        chk("fill_llu_rdy", 32'(o_llu_rdy), 32'd1);
        cyc();
        set_wb(1'b1, 5'd22, 32'hC000_0022); exp_wr(5'd22, 32'hC000_0022);
        set_llu(1'b1, 5'd6, 32'h0000_0066);
        #1;
        chk("held_llu_rdy", 32'(o_llu_rdy), 32'd0);
        cyc();
        chk("held_pend", o_pend_mask, 32'h0000_0018);
        set_wb(1'b0, 5'd0, 32'h0); exp_wr(5'd3, 32'h0000_0033);
        #1;
        chk("deq_llu_rdy", 32'(o_llu_rdy), 32'd1);
        cyc();
        set_llu(1'b0, 5'd0, 32'h0);
        chk("deq3_pend", o_pend_mask, 32'h0000_0050);
        exp_wr(5'd4, 32'h0000_0044);
        cyc();
        exp_wr(5'd6, 32'h0000_0066);
        cyc();
        chk("drained_pend", o_pend_mask, 32'd0);
        chk("drained_stall", 32'(o_stall_req), 32'd0);

        // 6. Conflict counter after a fresh reset
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        set_wb(1'b1, 5'd1, 32'hD000_0001); exp_wr(5'd1, 32'hD000_0001);
        set_llu(1'b1, 5'd10, 32'h0000_000A);
        cyc();
        set_llu(1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 5'd2, 32'hD000_0002); exp_wr(5'd2, 32'hD000_0002);
        cyc();
        set_wb(1'b1, 5'd3, 32'hD000_0003); exp_wr(5'd3, 32'hD000_0003);
        cyc();
        chk("conflict_cnt", o_conflict_cnt, 32'(EXP_CONF));
        set_wb(1'b0, 5'd0, 32'h0); exp_wr(5'd10, 32'h0000_000A);
        cyc();
        chk("conflict_cnt_after_drain", o_conflict_cnt, 32'(EXP_CONF));
        chk("final_pend", o_pend_mask, 32'd0);
        cyc(); cyc();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Sole owner of the register-file write port, sitting between the Writeback stage and the register file in Decode.
- Shares that single port between two requesters: the in-order pipeline writeback and a long-latency unit (LLU: mul/div, load-miss return).
- The pipeline always has priority. LLU results wait in a small FIFO.
- A starvation guard requests a one-cycle pipeline bubble so a waiting LLU result can drain.

Parameters:
- N, 32: data width; matches the `N define.
- BUF_DEPTH, 2: LLU result FIFO depth; must be a power of 2, minimum 2.
- MAX_WAIT, 4: number of cycles a FIFO head may lose arbitration before a stall is requested; minimum 1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_wb_wr, in, 1: pipeline requests an RF write this cycle.
- i_wb_rd, in, 5: pipeline destination register.
- i_wb_data, in, N: pipeline write data.
- i_llu_vld, in, 1: LLU result valid.
- i_llu_rd, in, 5: LLU destination register.
- i_llu_data, in, N: LLU result data.
- o_llu_rdy, out, 1: arbiter accepts the LLU result this cycle.
- o_rf_wr, out, 1: RF write enable (registered).
- o_rf_rd, out, 5: RF write address (registered).
- o_rf_data, out, N: RF write data (registered).
- o_stall_req, out, 1: request to Decode/hazard unit for a writeback bubble next cycle (registered).
- o_pend_mask, out, 32: bit r set while an accepted LLU result for xr is not yet written.
- o_conflict_cnt, out, 32: performance counter; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0) forces:
  - o_rf_wr=0, o_rf_rd=0, o_rf_data=0, o_stall_req=0, o_pend_mask=0, o_conflict_cnt=0.
  - FIFO empty, wait counter 0, state IDLE.
- Reset mid-operation discards all buffered results; no RF write occurs for them.
- Writes to x0 from either source are dropped: no RF write, and no FIFO enqueue.
- Grant is computed combinationally each cycle, and the o_rf_* registers capture the winner on the next clk edge (latency 1). Priority:
  1. Pipeline, if i_wb_wr=1.
  2. Otherwise the FIFO head, if the FIFO is non-empty.
  3. Otherwise a direct LLU bypass: i_llu_vld=1 with FIFO empty writes in the same cycle without enqueueing.
  4. Otherwise o_rf_wr<=0, and o_rf_rd/o_rf_data hold their previous values.
- o_llu_rdy = (count < BUF_DEPTH) OR (head dequeues this cycle). It is combinational from registered state plus i_wb_wr.
- LLU handshake: a transfer occurs when i_llu_vld && o_llu_rdy.
  - A non-bypassed transfer enqueues at the tail.
  - Simultaneous dequeue and enqueue when the FIFO is full is legal; count is unchanged.
- FIFO pointers wrap modulo BUF_DEPTH. Count has width clog2(BUF_DEPTH)+1.
- FIFO ordering is strict FIFO; the arbiter does not check WAW. The hazard unit must use o_pend_mask to hold any younger instruction whose rd is pending.
- o_pend_mask:
  - The bit is set on enqueue. The bypass path never sets it.
  - The bit is cleared on the cycle the entry is granted.
  - Two pending entries to the same rd are illegal (hazard unit guarantees this).
- States:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty, wait count < MAX_WAIT.
  - FORCE: o_stall_req=1.
- Transitions:
  - IDLE->PEND on enqueue.
  - PEND: wait count +1 each cycle the head loses to the pipeline; reset to 0 on head grant.
  - PEND->FORCE when wait count reaches MAX_WAIT.
  - FORCE->PEND or FORCE->IDLE on head grant (according to remaining count).
- In FORCE, Decode must present i_wb_wr=0. If i_wb_wr=1 anyway, the pipeline still wins, FORCE holds, and no data is lost.
- The wait counter saturates at MAX_WAIT.

Optional Feature:
- Macro RF_ARB_PERF_EN.
- Defined: o_conflict_cnt increments (wrapping at 2^32) on every cycle where i_wb_wr=1 (rd!=0) while the FIFO is non-empty or i_llu_vld=1 (rd!=0).
- Undefined: the counter register is not instantiated and o_conflict_cnt is tied to 0.
- Arbitration behaviour is identical in both builds.

Decomposition:
- Shared defines header (with `N and the opcodes):
  - RF_ADDR_W=5.
  - Arbiter state encodings ARB_IDLE=2'd0, ARB_PEND=2'd1, ARB_FORCE=2'd2.
- Sub-module rf_wr_fifo: parameterised synchronous FIFO holding {rd, data}, with push/pop/full/empty/count and async active-low reset. It is instantiated once.

Test Plan:
1. Reset mid-stream: 2 entries buffered, pulse rst_n low -> all outputs 0, o_llu_rdy=1, and no RF write for the buffered entries after release.
2. Pipeline-only: i_wb_wr=1, rd=5, data=0xDEADBEEF -> next cycle o_rf_wr=1, o_rf_rd=5, o_rf_data=0xDEADBEEF. With rd=0 -> o_rf_wr=0.
3. Bypass: FIFO empty, i_wb_wr=0, LLU rd=7, data=0x12 -> next cycle RF writes x7=0x12 and o_pend_mask stays 0.
4. Contention and starvation (MAX_WAIT=4): LLU rd=9 arrives while i_wb_wr is held at 1 -> o_pend_mask[9]=1. After 4 lost cycles, o_stall_req=1. Bench drops i_wb_wr -> x9 written next cycle, then o_stall_req=0 and o_pend_mask[9]=0.
5. Full FIFO (BUF_DEPTH=2), pipeline busy: LLU results rd=3 and rd=4 fill the FIFO, so o_llu_rdy=0 and a third result rd=6 is held. Release the pipeline -> writes x3, x4, x6 in order, and rd=6 is accepted on the x3 dequeue cycle.
6. With RF_ARB_PERF_EN: 3 cycles of pipeline plus pending FIFO -> o_conflict_cnt=3. Without the macro -> o_conflict_cnt stays 0 and all writes are unchanged.
